// File: rtl/data_mem_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_pipe_if
//  Description : Request/response bundle for the pipelined data memory.
//                Request side: req_valid/req_ready handshake carrying
//                req_write, req_addr (word index), req_wdata and req_be
//                (byte enables, bit i covers data bits [8i+7:8i]).
//                Response side: rsp_valid one-cycle strobe with rsp_rdata
//                and rsp_err (address out of range). The response side has
//                no back-pressure.
//                master : requester (drives the request, takes the response)
//                slave  : memory    (takes the request, drives the response)
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_pipe_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_be;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_pipe
//  Description : Word-addressed data memory with a valid/ready request port,
//                byte-enable writes, RD_LAT-deep registered response path,
//                out-of-range detection and a post-reset clear sequencer.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - data_mem_pipe_if.slave (request + response)
//                busy - clear sequence in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_pipe #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 32,
   parameter int DEPTH        = 64,
   parameter int RD_LAT       = 1,
   parameter int CLEAR_ON_RST = 1
) (
   input  wire logic       clk,
   input  wire logic       rst,
   data_mem_pipe_if.slave  bus,
   output logic            busy
);

   localparam int               BE_W      = DATA_W / 8;
   localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    cnt;
   logic                ready_q;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                pipe_v [RD_LAT];
   logic                pipe_e [RD_LAT];
   logic [DATA_W-1:0]   pipe_d [RD_LAT];

   logic                accept;
   logic                in_range;
   logic [IDX_W-1:0]    idx;

   // ready_q is only ever high in ST_READY, so it alone qualifies acceptance.
   assign accept   = bus.req_valid && ready_q;
   // Full-width compare: upper address bits must not alias into the array.
   assign in_range = ({1'b0, bus.req_addr} < DEPTH_EXT);
   assign idx      = bus.req_addr[IDX_W-1:0];

   // ------------------------------------------------------------------------
   // Control FSM: clear sequencer, registered ready/busy.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
         cnt     <= '0;
         ready_q <= 1'b0;
         busy    <= (CLEAR_ON_RST != 0);
      end else begin
         case (state)
            ST_CLEAR: begin
               if (cnt == LAST_IDX) begin
                  state   <= ST_READY;
                  ready_q <= 1'b1;
                  busy    <= 1'b0;
               end else begin
                  cnt <= cnt + IDX_W'(1);
               end
            end
            ST_READY: begin
               ready_q <= 1'b1;
               busy    <= 1'b0;
            end
            default: begin
               state   <= ST_CLEAR;
               cnt     <= '0;
               ready_q <= 1'b0;
               busy    <= 1'b1;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Storage array. Kept free of a reset branch so it maps onto RAM; the
   // clear sequencer zeroes it one word per cycle instead.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == ST_CLEAR) begin
            mem[cnt] <= '0;
         end else if (accept && bus.req_write && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
               if (bus.req_be[b]) begin
                  mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Response shift register. Stage 0 is loaded at the accept edge with the
   // array contents seen at that edge; the last stage drives the outputs.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_e[i] <= 1'b0;
            pipe_d[i] <= '0;
         end
      end else begin
         pipe_v[0] <= accept;
         pipe_e[0] <= accept && !in_range;
         pipe_d[0] <= (accept && !bus.req_write && in_range) ? mem[idx] : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_e[i] <= pipe_e[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = pipe_v[RD_LAT-1];
   assign bus.rsp_err   = pipe_e[RD_LAT-1];
   assign bus.rsp_rdata = pipe_d[RD_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_data_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_pipe
//  Description : Self-checking bench for data_mem_pipe. Three instances with
//                RD_LAT = 1, 2, 4 share one request stream and are compared
//                every cycle against a behavioural model (word array plus a
//                per-instance response schedule). A fourth instance with
//                CLEAR_ON_RST = 0 checks the no-clear start-up behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_pipe;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 64;
   localparam int NI    = 3;
   localparam int LAT [NI] = '{1, 2, 4};

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        valid_d;
   logic        write_d;
   logic [31:0] addr_d;
   logic [31:0] wdata_d;
   logic [3:0]  be_d;

   logic        busy_q [NI];
   logic        busy_nc;

   data_mem_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
   data_mem_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();
   data_mem_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) if4 ();
   data_mem_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) ifnc ();

   assign if1.req_valid = valid_d;  assign if1.req_write = write_d;
   assign if1.req_addr  = addr_d;   assign if1.req_wdata = wdata_d;
   assign if1.req_be    = be_d;
   assign if2.req_valid = valid_d;  assign if2.req_write = write_d;
   assign if2.req_addr  = addr_d;   assign if2.req_wdata = wdata_d;
   assign if2.req_be    = be_d;
   assign if4.req_valid = valid_d;  assign if4.req_write = write_d;
   assign if4.req_addr  = addr_d;   assign if4.req_wdata = wdata_d;
   assign if4.req_be    = be_d;
   assign ifnc.req_valid = 1'b0;    assign ifnc.req_write = 1'b0;
   assign ifnc.req_addr  = '0;      assign ifnc.req_wdata = '0;
   assign ifnc.req_be    = '0;

   data_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1), .CLEAR_ON_RST(1))
      u_l1 (.clk(clk), .rst(rst), .bus(if1.slave), .busy(busy_q[0]));
   data_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(2), .CLEAR_ON_RST(1))
      u_l2 (.clk(clk), .rst(rst), .bus(if2.slave), .busy(busy_q[1]));
   data_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(4), .CLEAR_ON_RST(1))
      u_l4 (.clk(clk), .rst(rst), .bus(if4.slave), .busy(busy_q[2]));
   data_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1), .CLEAR_ON_RST(0))
      u_nc (.clk(clk), .rst(rst), .bus(ifnc.slave), .busy(busy_nc));

   logic        rv  [NI];
   logic        re  [NI];
   logic        rdy [NI];
   logic [31:0] rd  [NI];
   assign rv[0] = if1.rsp_valid; assign re[0] = if1.rsp_err; assign rdy[0] = if1.req_ready; assign rd[0] = if1.rsp_rdata;
   assign rv[1] = if2.rsp_valid; assign re[1] = if2.rsp_err; assign rdy[1] = if2.req_ready; assign rd[1] = if2.rsp_rdata;
   assign rv[2] = if4.rsp_valid; assign re[2] = if4.rsp_err; assign rdy[2] = if4.req_ready; assign rd[2] = if4.rsp_rdata;

   // ---------------- reference model ----------------
   logic [31:0] mem_m [DEPTH];
   logic        sv [NI][8];       // expected response, indexed by edge mod 8
   logic        se [NI][8];
   logic [31:0] sd [NI][8];
   int          n_edge;
   int          clear_left;
   logic        ready_m, busy_m, known;
   logic        nc_ready_m, nc_known;

   logic [31:0] last_d [NI];
   logic        last_e [NI];
   int          pulse_cnt;

   int          n_tests;
   int          n_fail;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n_edge);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++)
         if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
      return res;
   endfunction

   // Drive one cycle of inputs, predict the effect of the coming edge,
   // then check every instance after the edge.
   task automatic cycle(input logic r, input logic v, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      int          e;
      int          slot;
      logic        inr;
      logic [31:0] rdat;
      rst = r; valid_d = v; write_d = w; addr_d = a; wdata_d = d; be_d = b;
      e = n_edge + 1;
      if (r) begin
         for (int k = 0; k < NI; k++)
            for (int s = 0; s < 8; s++) begin
               sv[k][s] = 1'b0; se[k][s] = 1'b0; sd[k][s] = '0;
            end
         ready_m = 1'b0; busy_m = 1'b1; clear_left = DEPTH; known = 1'b1;
         nc_ready_m = 1'b0; nc_known = 1'b1;
      end else begin
         if (v && ready_m) begin
            inr  = (a < 32'(DEPTH));
            rdat = (!w && inr) ? mem_m[a % DEPTH] : 32'h0;
            if (w && inr) mem_m[a % DEPTH] = merge(mem_m[a % DEPTH], d, b);
            for (int k = 0; k < NI; k++) begin
               slot = (e + LAT[k] - 1) % 8;
               sv[k][slot] = 1'b1; se[k][slot] = !inr; sd[k][slot] = rdat;
            end
         end
         if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) begin
               for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
               ready_m = 1'b1; busy_m = 1'b0;
            end
         end
         nc_ready_m = 1'b1;
      end
      @(posedge clk);
      n_edge = e;
      @(negedge clk);
      if (known) begin
         slot = e % 8;
         for (int k = 0; k < NI; k++) begin
            check($sformatf("req_ready[L%0d]", LAT[k]), rdy[k], ready_m);
            check($sformatf("busy[L%0d]", LAT[k]), busy_q[k], busy_m);
            check($sformatf("rsp_valid[L%0d]", LAT[k]), rv[k], sv[k][slot]);
            if (sv[k][slot]) begin
               check($sformatf("rsp_err[L%0d]", LAT[k]), re[k], se[k][slot]);
               check($sformatf("rsp_rdata[L%0d]", LAT[k]), rd[k], sd[k][slot]);
            end
            if (r) begin
               check($sformatf("rst_rdata[L%0d]", LAT[k]), rd[k], 0);
               check($sformatf("rst_err[L%0d]", LAT[k]), re[k], 0);
            end
            if (rv[k]) begin
               last_d[k] = rd[k];
               last_e[k] = re[k];
            end
            sv[k][slot] = 1'b0;
         end
         if (rv[2]) pulse_cnt++;
      end
      if (nc_known) begin
         check("nc_req_ready", ifnc.req_ready, nc_ready_m);
         check("nc_busy", busy_nc, 1'b0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      cycle(1'b0, 1'b1, 1'b1, a, d, b);
   endtask

   task automatic rdq(input logic [31:0] a);
      cycle(1'b0, 1'b1, 1'b0, a, 32'h0, 4'h0);
   endtask

   task automatic mark();
      for (int k = 0; k < NI; k++) begin
         last_d[k] = 32'hA5A5A5A5;
         last_e[k] = 1'bx;
      end
   endtask

   // Idle until req_ready rises (bounded) and check the clear length.
   task automatic wait_clear(input string tag);
      int cnt;
      cnt = 0;
      do begin
         idle(1);
         cnt++;
      end while (!rdy[0] && cnt < 200);
      check(tag, cnt, DEPTH);
   endtask

   initial begin
      logic        rw, rvld;
      logic [31:0] ra;
      n_tests = 0; n_fail = 0; n_edge = 0; pulse_cnt = 0;
      known = 1'b0; nc_known = 1'b0; ready_m = 1'b0; busy_m = 1'b1; clear_left = 0;
      nc_ready_m = 1'b0;
      rst = 1'b1; valid_d = 1'b0; write_d = 1'b0; addr_d = '0; wdata_d = '0; be_d = '0;
      for (int k = 0; k < NI; k++)
         for (int s = 0; s < 8; s++) begin
            sv[k][s] = 1'b0; se[k][s] = 1'b0; sd[k][s] = '0;
         end
      mark();
      @(negedge clk);

      // Reset for two cycles, then the clear must take exactly DEPTH edges.
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      wait_clear("clear_len");

      // Last word reads back as zero.
      mark();
      rdq(32'd63);
      idle(5);
      check("rd63_data", last_d[0], 32'h0);
      check("rd63_err", last_e[0], 1'b0);

      // Byte-enable merge.
      mark();
      wr(32'd5, 32'hDEADBEEF, 4'b1111);
      wr(32'd5, 32'h00001200, 4'b0010);
      rdq(32'd5);
      idle(5);
      check("be_merge", last_d[0], 32'hDEAD12EF);

      // Latency sweep across the three instances.
      mark();
      wr(32'd10, 32'h12345678, 4'hF);
      rdq(32'd10);
      idle(6);
      for (int k = 0; k < NI; k++)
         check($sformatf("lat_data[L%0d]", LAT[k]), last_d[k], 32'h12345678);

      // Write-then-read on consecutive accepts, then a burst of 8 reads.
      mark();
      wr(32'd3, 32'd7, 4'hF);
      rdq(32'd3);
      idle(6);
      check("wr_rd_fwd", last_d[0], 32'd7);
      pulse_cnt = 0;
      for (int i = 0; i < 8; i++) rdq(32'(i));
      idle(6);
      check("burst_pulses", pulse_cnt, 8);

      // Out-of-range read and write, then address 0 must be untouched.
      mark();
      rdq(32'd64);
      idle(5);
      check("oor_rd_err", last_e[0], 1'b1);
      check("oor_rd_data", last_d[0], 32'h0);
      mark();
      wr(32'h80000000, 32'hFFFFFFFF, 4'hF);
      idle(5);
      check("oor_wr_err", last_e[2], 1'b1);
      check("oor_wr_data", last_d[2], 32'h0);
      mark();
      rdq(32'd0);
      idle(5);
      check("addr0_kept", last_d[0], 32'h0);

      // Randomised traffic: mostly in range, some just past the end, a few huge.
      for (int i = 0; i < 1500; i++) begin
         rvld = ($urandom_range(0, 3) != 0);
         rw   = $urandom_range(0, 1) != 0;
         ra   = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 70));
         cycle(1'b0, rvld, rw, ra, $urandom, 4'($urandom_range(0, 15)));
      end
      idle(5);

      // Reset with three reads in flight, and again part-way through the clear.
      pulse_cnt = 0;
      rdq(32'd1);
      rdq(32'd2);
      rdq(32'd3);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      idle(20);
      check("stale_rsp_l4", pulse_cnt, 0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      wait_clear("reclear_len");

      // Memory is zero again after the repeated clear.
      for (int i = 0; i < 40; i++) begin
         rvld = ($urandom_range(0, 4) != 0);
         cycle(1'b0, rvld, ($urandom_range(0, 3) == 0), 32'($urandom_range(0, 66)),
               $urandom, 4'($urandom_range(0, 15)));
      end
      idle(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
